// File: rtl/spm_pkg.sv
// spm_pkg: opcodes, FSM state encoding and field-width helpers shared by the SPM core
package spm_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_RD  = 4'h5;
  localparam logic [3:0] OP_WR  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_BRZ = 4'h8;
  localparam logic [3:0] OP_RD2 = 4'h9;
  localparam logic [3:0] OP_BRC = 4'hA;
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_OPND,
    S_AGEN,
    S_DATA,
    S_WRITE,
    S_BR2,
    S_HALT
  } state_e;
  function automatic int reg_bits(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction
  function automatic bit word_size_ok(input int word_size, input int num_regs);
    return (num_regs >= 2) && ((num_regs & (num_regs - 1)) == 0) &&
           (4 + 2 * reg_bits(num_regs) <= word_size);
  endfunction
endpackage

// File: rtl/spm_regfile.sv
// spm_regfile: NUM_REGS x WORD_SIZE registers, two async read ports, one sync write port, async clear
module spm_regfile
  import spm_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS = 4,
  localparam int RB = reg_bits(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RB-1:0]        ra0,
  input  logic [RB-1:0]        ra1,
  output logic [WORD_SIZE-1:0] rd0,
  output logic [WORD_SIZE-1:0] rd1,
  input  logic                 we,
  input  logic [RB-1:0]        wa,
  input  logic [WORD_SIZE-1:0] wd
);
  logic [NUM_REGS-1:0][WORD_SIZE-1:0] regs_q, regs_d;
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) regs_q <= '0;
    else regs_q <= regs_d;
  assign rd0 = regs_q[ra0];
  assign rd1 = regs_q[ra1];
endmodule

// File: rtl/spm_core_param.sv
// spm_core_param: multicycle SPM core (FSM, PC, IR, regfile, ALU, flags) with a req/ready memory port.
// Define SPM_CARRY_EN to add the C flag, the BRC opcode and the carry_flag output.
module spm_core_param
  import spm_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 zero_flag,
  output logic                 instr_done,
  output logic                 halted
`ifdef SPM_CARRY_EN
  ,
  output logic                 carry_flag
`endif
);
  localparam int W = WORD_SIZE;
  localparam int RB = reg_bits(NUM_REGS);
`ifdef SPM_CARRY_EN
  localparam int AW = W + 1;
`else
  localparam int AW = W;
`endif
  if (!word_size_ok(WORD_SIZE, NUM_REGS)) begin : g_bad_cfg
    $error("spm_core_param: NUM_REGS must be a power of 2 >= 2 with 4+2*clog2(NUM_REGS) <= WORD_SIZE");
  end
  state_e state_q, state_d;
  logic [W-1:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, y_q, y_d;
  logic z_q, z_d;
  logic [3:0] opc;
  logic [RB-1:0] src, dst;
  logic [W-1:0] r_src, r_dst, rf_wdata;
  logic rf_we, done, is_bc, br_take;
  logic [AW-1:0] alu;
  assign opc = ir_q[W-1 -: 4];
  assign src = ir_q[2*RB-1 -: RB];
  assign dst = ir_q[RB-1:0];
  assign alu = opc == OP_ADD ? AW'(r_dst) + AW'(y_q) :
               opc == OP_SUB ? AW'(r_dst) - AW'(y_q) : AW'(r_dst & y_q);
`ifdef SPM_CARRY_EN
  logic c_q, c_d;
  assign is_bc = opc == OP_BRZ || opc == OP_BRC;
  assign br_take = opc == OP_BRC ? c_q : z_q;
  // ADD/SUB leave carry/borrow in the top ALU bit; AND and NOT clear it
  assign c_d = state_q == S_EXEC ? alu[W] : (state_q == S_DECODE && opc == OP_NOT) ? 1'b0 : c_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) c_q <= 1'b0;
    else c_q <= c_d;
  assign carry_flag = c_q;
`else
  assign is_bc = opc == OP_BRZ;
  assign br_take = z_q;
`endif
  spm_regfile #(.WORD_SIZE(W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk),
    .rst(rst),
    .ra0(src),
    .ra1(dst),
    .rd0(r_src),
    .rd1(r_dst),
    .we(rf_we),
    .wa(dst),
    .wd(rf_wdata)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    y_d = y_q;
    z_d = z_q;
    rf_we = 1'b0;
    rf_wdata = alu[W-1:0];
    done = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH:
        if (mem_ready) begin
          ir_d = mem_rdata;
          pc_d = pc_q + W'(1);
          state_d = S_DECODE;
        end
      S_DECODE:
        case (opc)
          OP_NOP: begin
            done = 1'b1;
            state_d = S_FETCH;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            y_d = r_src;
            state_d = S_EXEC;
          end
          OP_NOT: begin
            rf_we = 1'b1;
            rf_wdata = ~r_src;
            z_d = &r_src;
            done = 1'b1;
            state_d = S_FETCH;
          end
          OP_RD, OP_RD2, OP_WR, OP_BR: state_d = S_OPND;
          default:
            if (is_bc) begin
              // not-taken conditional branch skips its operand word
              pc_d = br_take ? pc_q : pc_q + W'(1);
              done = !br_take;
              state_d = br_take ? S_OPND : S_FETCH;
            end else begin
              state_d = S_HALT;
            end
        endcase
      S_EXEC: begin
        rf_we = 1'b1;
        z_d = ~|alu[W-1:0];
        done = 1'b1;
        state_d = S_FETCH;
      end
      S_OPND:
        if (mem_ready) begin
          a_d = mem_rdata;
          pc_d = pc_q + W'(1);
          state_d = opc == OP_RD ? S_DATA : opc == OP_RD2 ? S_AGEN : opc == OP_WR ? S_WRITE : S_BR2;
        end
      S_AGEN: begin
        a_d = a_q + r_src;
        state_d = S_DATA;
      end
      S_DATA:
        if (mem_ready) begin
          rf_we = 1'b1;
          rf_wdata = mem_rdata;
          done = 1'b1;
          state_d = S_FETCH;
        end
      S_WRITE:
        if (mem_ready) begin
          done = 1'b1;
          state_d = S_FETCH;
        end
      S_BR2:
        if (mem_ready) begin
          pc_d = mem_rdata;
          done = 1'b1;
          state_d = S_FETCH;
        end
      default: state_d = S_HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q <= '0;
      y_q <= '0;
      z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  // request and address decode straight from state so reset drops mem_req immediately
  assign mem_req = state_q inside {S_FETCH, S_OPND, S_DATA, S_WRITE, S_BR2};
  assign mem_we = state_q == S_WRITE;
  assign mem_addr = (state_q inside {S_FETCH, S_OPND}) ? pc_q :
                    (state_q inside {S_DATA, S_WRITE, S_BR2}) ? a_q : '0;
  assign mem_wdata = mem_we ? r_src : '0;
  assign pc = pc_q;
  assign zero_flag = z_q;
  assign instr_done = done;
  assign halted = state_q == S_HALT;
endmodule

// File: tb/tb_spm_core_param.sv
// tb_spm_core_param: directed programs against a stallable memory model, hand-computed results
module tb_spm_core_param;
  logic clk = 1'b0, rst = 1'b0;
  logic mem_req, mem_we, zero_flag, instr_done, halted;
  logic mem_ready = 1'b0;
  logic [7:0] mem_addr, mem_wdata, pc;
  logic [7:0] mem_rdata = '0;
`ifdef SPM_CARRY_EN
  logic carry_flag;
`endif
  logic [7:0] mem [256];
  int n_cmp = 0, n_err = 0, stall_n = 0, cnt = 0, acc_n = 0, viol = 0;
  logic done_seen = 1'b0, prev_req = 1'b0, prev_rdy = 1'b0, prev_we = 1'b0;
  logic [7:0] prev_addr = '0, prev_wd = '0;
  always #5 clk = ~clk;
  spm_core_param #(.WORD_SIZE(8), .NUM_REGS(4), .RESET_PC(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc(pc),
    .zero_flag(zero_flag),
    .instr_done(instr_done),
    .halted(halted)
`ifdef SPM_CARRY_EN
    ,
    .carry_flag(carry_flag)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one cycle: answer the memory at negedge, sample outputs, commit completing writes
  task automatic step();
    @(negedge clk);
    if (mem_req) begin
      mem_ready = (cnt >= stall_n);
      cnt = mem_ready ? 0 : cnt + 1;
    end else begin
      mem_ready = 1'b0;
      cnt = 0;
    end
    mem_rdata = mem[mem_addr];
    if (mem_req && prev_req && !prev_rdy &&
        {mem_addr, mem_we, mem_wdata} != {prev_addr, prev_we, prev_wd}) viol++;
    #1;
    done_seen = instr_done;
    if (mem_req && mem_ready) begin
      acc_n++;
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
    {prev_req, prev_rdy, prev_addr, prev_we, prev_wd} = {mem_req, mem_ready, mem_addr, mem_we, mem_wdata};
  endtask
  task automatic exec(input string tag, output int cyc);
    cyc = 0;
    acc_n = 0;
    do begin
      step();
      cyc++;
    end while (!done_seen && cyc < 60);
    chk({tag, "_done"}, 32'(done_seen), 32'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    cnt = 0;
    prev_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic clear_mem();
    foreach (mem[i]) mem[i] = '0;
  endtask
  initial begin
    int c, reqs;
    clear_mem();
    mem[8'h00] = 8'h51; mem[8'h01] = 8'h80; mem[8'h02] = 8'h64; mem[8'h03] = 8'h90;
    mem[8'h80] = 8'h05;
    do_reset();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_outs", 32'({mem_req, mem_we, mem_addr, mem_wdata, zero_flag, instr_done, halted}), 32'h0);
    exec("t1_rd", c);
    chk("t1_rd_cyc", 32'(c), 32'd4);
    chk("t1_r1", 32'(dut.u_rf.regs_q[1]), 32'h05);
    stall_n = 10;
    c = 0;
    do begin
      step();
      c++;
    end while (!(mem_req && mem_we) && c < 40);
    chk("t1_in_write", 32'(mem_req && mem_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t1_abort_req", 32'({mem_req, mem_we}), 32'd0);
    chk("t1_abort_pc", 32'(pc), 32'h00);
    stall_n = 0;
    do_reset();
    chk("t1_regs", 32'(dut.u_rf.regs_q), 32'h0);
    chk("t1_pc", 32'(pc), 32'h00);
    clear_mem();
    mem[8'h00] = 8'h51; mem[8'h01] = 8'h80; mem[8'h02] = 8'h52; mem[8'h03] = 8'h81;
    mem[8'h04] = 8'h26; mem[8'h05] = 8'h50; mem[8'h06] = 8'h82; mem[8'h07] = 8'h53;
    mem[8'h08] = 8'h83; mem[8'h09] = 8'h33; mem[8'h0A] = 8'h15; mem[8'h0B] = 8'h4C;
    mem[8'h80] = 8'h05; mem[8'h81] = 8'h03; mem[8'h82] = 8'h0F; mem[8'h83] = 8'hF0;
    do_reset();
    exec("t2_rd1", c);
    exec("t2_rd2", c);
    exec("t2_sub", c);
    chk("t2_sub_cyc", 32'(c), 32'd3);
    chk("t2_sub_r2", 32'(dut.u_rf.regs_q[2]), 32'hFE);
    chk("t2_sub_z", 32'(zero_flag), 32'd0);
    exec("t2_rd0", c);
    exec("t2_rd3", c);
    exec("t2_and", c);
    chk("t2_and_r3", 32'(dut.u_rf.regs_q[3]), 32'h00);
    chk("t2_and_z", 32'(zero_flag), 32'd1);
    exec("t2_add", c);
    chk("t2_add_r1", 32'(dut.u_rf.regs_q[1]), 32'h0A);
    chk("t2_add_z", 32'(zero_flag), 32'd0);
    exec("t2_not", c);
    chk("t2_not_cyc", 32'(c), 32'd2);
    chk("t2_not_r0", 32'(dut.u_rf.regs_q[0]), 32'hFF);
    exec("t2_nop", c);
    chk("t2_nop_cyc", 32'(c), 32'd2);
    chk("t2_nop_pc", 32'(pc), 32'h0D);
    clear_mem();
    mem[8'h00] = 8'h50; mem[8'h01] = 8'h30; mem[8'h02] = 8'h91; mem[8'h03] = 8'hF0;
    mem[8'h30] = 8'h20; mem[8'h10] = 8'hA5;
    do_reset();
    exec("t3_rd", c);
    exec("t3_rd2", c);
    chk("t3_rd2_cyc", 32'(c), 32'd5);
    chk("t3_rd2_r1", 32'(dut.u_rf.regs_q[1]), 32'hA5);
    chk("t3_pc", 32'(pc), 32'h04);
    clear_mem();
    mem[8'h00] = 8'h52; mem[8'h01] = 8'h40; mem[8'h02] = 8'h68; mem[8'h03] = 8'h50;
    mem[8'h40] = 8'h77;
    stall_n = 3;
    viol = 0;
    do_reset();
    exec("t4_rd", c);
    chk("t4_rd_cyc", 32'(c), 32'd13);
    chk("t4_rd_r2", 32'(dut.u_rf.regs_q[2]), 32'h77);
    exec("t4_wr", c);
    chk("t4_wr_cyc", 32'(c), 32'd13);
    chk("t4_wr_mem", 32'(mem[8'h50]), 32'h77);
    chk("t4_stable", 32'(viol), 32'd0);
    stall_n = 0;
    clear_mem();
    mem[8'h00] = 8'h80; mem[8'h01] = 8'h20; mem[8'h02] = 8'h70; mem[8'h03] = 8'h40;
    mem[8'h40] = 8'h80; mem[8'h80] = 8'h30; mem[8'h81] = 8'h80; mem[8'h82] = 8'h41;
    mem[8'h41] = 8'hC0; mem[8'hC0] = 8'hF0;
    do_reset();
    exec("t5_brz_nt", c);
    chk("t5_brz_nt_cyc", 32'(c), 32'd2);
    chk("t5_brz_nt_pc", 32'(pc), 32'h02);
    chk("t5_brz_nt_acc", 32'(acc_n), 32'd1);
    exec("t5_br", c);
    chk("t5_br_cyc", 32'(c), 32'd4);
    chk("t5_br_pc", 32'(pc), 32'h80);
    exec("t5_and", c);
    chk("t5_and_z", 32'(zero_flag), 32'd1);
    exec("t5_brz_t", c);
    chk("t5_brz_t_pc", 32'(pc), 32'hC0);
    chk("t5_brz_t_acc", 32'(acc_n), 32'd3);
    repeat (3) step();
    chk("t6_halted", 32'(halted), 32'd1);
    reqs = 0;
    repeat (5) begin
      step();
      if (mem_req) reqs++;
    end
    chk("t6_no_req", 32'(reqs), 32'd0);
    chk("t6_pc", 32'(pc), 32'hC1);
    clear_mem();
    mem[8'h00] = 8'h70; mem[8'h01] = 8'h50; mem[8'h50] = 8'hFF;
    do_reset();
    exec("wrap_br", c);
    chk("wrap_br_pc", 32'(pc), 32'hFF);
    exec("wrap_nop", c);
    chk("wrap_pc", 32'(pc), 32'h00);
`ifdef SPM_CARRY_EN
    clear_mem();
    mem[8'h00] = 8'h50; mem[8'h01] = 8'h20; mem[8'h02] = 8'h51; mem[8'h03] = 8'h21;
    mem[8'h04] = 8'h14; mem[8'h05] = 8'hA0; mem[8'h06] = 8'h30;
    mem[8'h20] = 8'hFF; mem[8'h21] = 8'h01; mem[8'h30] = 8'h44;
    do_reset();
    exec("c_rd0", c);
    exec("c_rd1", c);
    exec("c_add", c);
    chk("c_add_r0", 32'(dut.u_rf.regs_q[0]), 32'h00);
    chk("c_add_cz", 32'({carry_flag, zero_flag}), 32'h3);
    exec("c_brc", c);
    chk("c_brc_pc", 32'(pc), 32'h44);
`else
    clear_mem();
    mem[8'h00] = 8'hA0;
    do_reset();
    repeat (3) step();
    chk("brc_undef_halt", 32'(halted), 32'd1);
    chk("brc_undef_req", 32'(mem_req), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
